stopwatch_core: RTL and testbench

BCD minutes:seconds stopwatch that sits directly downstream of the 1 Hz clock divider. It consumes the divider's one-cycle `tc_1sec` pulse as its `tick` input and counts from 00:00 to 59:59. A start/stop/clear state machine controls counting. It drives four BCD digits to the seven-segment display stage.

---
 rtl/stopwatch_pkg.sv | 17 +
 rtl/stopwatch_bcd_digit_mod.sv | 29 ++
 rtl/stopwatch_core.sv | 118 +++++++++++
 tb/tb_stopwatch_core.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD minutes:seconds stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_ONES_MAX = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t MIN_ONES_MAX = 4'd9;
    localparam bcd_t MIN_TENS_MAX = 4'd5;

endpackage

// File: rtl/stopwatch_bcd_digit_mod.sv
// One BCD digit of the stopwatch: counts 0..MAX on en, synchronous clear.
// tc is combinational so a full carry ripple resolves in a single cycle.
module bcd_digit_mod
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output bcd_t q,
    output logic tc
);

    assign tc = en && (q == MAX);

    // Digit register: clear wins, otherwise wrap at MAX or increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= (q == MAX) ? '0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// BCD 00:00..59:59 stopwatch driven by the 1 Hz tick from the clock divider.
// Optional lap/freeze display hold is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_core
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap
);

    sw_state_t state, state_nxt;

    bcd_t so_q, st_q, mo_q, mt_q;
    logic so_tc, st_tc, mo_tc, mt_tc;
    logic cnt_en;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: clear overrides everything, start_stop toggles run/pause.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else if (start_stop) begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = PAUSE;
                PAUSE:   state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign running = (state == RUN);

    // Only ticks sampled while already in RUN count; clear suppresses them.
    assign cnt_en = (state == RUN) && tick && !clear;

    bcd_digit_mod #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk(clk), .reset(reset), .en(cnt_en), .clr(clear), .q(so_q), .tc(so_tc)
    );
    bcd_digit_mod #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .reset(reset), .en(so_tc),  .clr(clear), .q(st_q), .tc(st_tc)
    );
    bcd_digit_mod #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clk(clk), .reset(reset), .en(st_tc),  .clr(clear), .q(mo_q), .tc(mo_tc)
    );
    bcd_digit_mod #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .reset(reset), .en(mo_tc),  .clr(clear), .q(mt_q), .tc(mt_tc)
    );

    // Rollover pulse: top digit carry only fires on a counted tick at 59:59.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wrap <= 1'b0;
        else       wrap <= mt_tc;
    end

`ifdef STOPWATCH_LAP_EN
    logic frozen;
    bcd_t hold_so, hold_st, hold_mo, hold_mt;

    // Lap toggles the freeze in RUN only; clear always releases it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frozen  <= 1'b0;
            hold_so <= '0;
            hold_st <= '0;
            hold_mo <= '0;
            hold_mt <= '0;
        end else if (clear) begin
            frozen <= 1'b0;
        end else if (lap && state == RUN) begin
            if (frozen) begin
                frozen <= 1'b0;
            end else begin
                frozen  <= 1'b1;
                hold_so <= so_q;
                hold_st <= st_q;
                hold_mo <= mo_q;
                hold_mt <= mt_q;
            end
        end
    end

    // Display mux: held digits while frozen, live digits otherwise.
    always_comb begin
        sec_ones = frozen ? hold_so : so_q;
        sec_tens = frozen ? hold_st : st_q;
        min_ones = frozen ? hold_mo : mo_q;
        min_tens = frozen ? hold_mt : mt_q;
    end
`else
    logic unused_lap;
    assign unused_lap = lap;

    // Display is always the live count.
    always_comb begin
        sec_ones = so_q;
        sec_tens = st_q;
        min_ones = mo_q;
        min_tens = mt_q;
    end
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: directed scenarios plus random
// pulses, compared against a seconds-count reference model.
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, start_stop, clear, lap;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, wrap;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: elapsed seconds plus run/pause flags.
    int m_cnt;
    int m_hold;
    bit m_run;
    bit m_frz;
    bit m_wrap;

    stopwatch_core dut (
        .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop),
        .clear(clear), .lap(lap),
        .sec_ones(sec_ones), .sec_tens(sec_tens),
        .min_ones(min_ones), .min_tens(min_tens),
        .running(running), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int disp_val();
        return m_frz ? m_hold : m_cnt;
    endfunction

    task automatic chk_model(input string tag);
        int d;
        d = disp_val();
        chk({tag, ".sec_ones"}, int'(sec_ones), d % 10);
        chk({tag, ".sec_tens"}, int'(sec_tens), (d / 10) % 6);
        chk({tag, ".min_ones"}, int'(min_ones), (d / 60) % 10);
        chk({tag, ".min_tens"}, int'(min_tens), d / 600);
        chk({tag, ".running"},  int'(running),  int'(m_run));
        chk({tag, ".wrap"},     int'(wrap),     int'(m_wrap));
    endtask

    task automatic chk_time(input string tag, input int mm, input int ss);
        chk({tag, ".mm:ss"},
            int'(min_tens) * 600 + int'(min_ones) * 60 + int'(sec_tens) * 10 + int'(sec_ones),
            mm * 60 + ss);
    endtask

    function automatic void model_reset();
        m_cnt = 0; m_hold = 0; m_run = 0; m_frz = 0; m_wrap = 0;
    endfunction

    // Apply one cycle of the spec's rules to the model.
    function automatic void model_step(input bit t, input bit s, input bit c, input bit l);
        bit counted;
        int old;
        if (c) begin
            model_reset();
            return;
        end
        old     = m_cnt;
        counted = m_run && t;
        m_wrap  = counted && (m_cnt == 3599);
        if (counted) m_cnt = (m_cnt + 1) % 3600;
`ifdef STOPWATCH_LAP_EN
        if (l && m_run) begin
            if (m_frz) m_frz = 0;
            else begin m_frz = 1; m_hold = old; end
        end
`else
        if (l) m_hold = m_hold;
`endif
        // start_stop: IDLE or PAUSE -> RUN, RUN -> PAUSE
        if (s) m_run = !m_run;
    endfunction

    // Drive one cycle of inputs (driven and sampled on the falling edge).
    task automatic cyc(input bit t, input bit s, input bit c, input bit l);
        tick = t; start_stop = s; clear = c; lap = l;
        @(posedge clk);
        model_step(t, s, c, l);
        @(negedge clk);
        tick = 0; start_stop = 0; clear = 0; lap = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
    endtask

    initial begin
        reset = 1; tick = 0; start_stop = 0; clear = 0; lap = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_model("reset");
        chk_time("reset", 0, 0);
        reset = 0;
        @(negedge clk);

        // Ticks in IDLE are discarded.
        ticks(3);
        chk_model("idle_ticks");

        // Start and count 75 ticks -> 01:15.
        cyc(0, 1, 0, 0);
        ticks(75);
        chk_model("count75");
        chk_time("count75", 1, 15);
        chk("count75.running", int'(running), 1);

        // Pause at 00:10.
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        ticks(10);
        cyc(0, 1, 0, 0);
        ticks(5);
        chk_model("pause_hold");
        chk_time("pause_hold", 0, 10);
        cyc(1, 1, 0, 0);   // resume with coincident tick: not counted
        chk_model("resume_tick");
        chk_time("resume_tick", 0, 10);
        ticks(1);
        chk_time("resume_count", 0, 11);
        cyc(1, 1, 0, 0);   // pause with coincident tick: counted
        chk_model("pause_tick");
        chk_time("pause_tick", 0, 12);

        // Rollover.
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        ticks(3599);
        chk_model("pre_wrap");
        chk_time("pre_wrap", 59, 59);
        chk("pre_wrap.wrap", int'(wrap), 0);
        ticks(1);
        chk_model("wrap");
        chk("wrap.pulse", int'(wrap), 1);
        chk("wrap.running", int'(running), 1);
        cyc(0, 0, 0, 0);
        chk("wrap.single", int'(wrap), 0);

        // Priority: clear + start_stop + tick in RUN at 02:30.
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        ticks(150);
        chk_time("pre_prio", 2, 30);
        cyc(1, 1, 1, 0);
        chk_model("prio");
        chk("prio.running", int'(running), 0);
        chk("prio.wrap", int'(wrap), 0);

        // Clear at 59:59 with a tick: no wrap pulse.
        cyc(0, 1, 0, 0);
        ticks(3599);
        cyc(1, 0, 1, 0);
        chk_model("clear_at_wrap");

        // Asynchronous reset mid-run at 00:42.
        cyc(0, 1, 0, 0);
        ticks(42);
        chk_time("pre_reset", 0, 42);
        #2 reset = 1;
        #1;
        chk_time("async_reset", 0, 0);
        chk("async_reset.running", int'(running), 0);
        model_reset();
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        ticks(5);
        chk_model("post_reset");
        chk_time("post_reset", 0, 0);

        // Lap at 00:20 then 10 ticks, then release.
        cyc(0, 1, 0, 0);
        ticks(20);
        cyc(0, 0, 0, 1);
        ticks(10);
        chk_model("lap_frozen");
        cyc(0, 0, 0, 1);
        chk_model("lap_release");
        chk_time("lap_release", 0, 30);
`ifdef STOPWATCH_LAP_EN
        // Lap while paused is ignored.
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        ticks(2);
        chk_model("lap_paused");
        // Clear releases a freeze.
        cyc(0, 0, 0, 1);
        ticks(3);
        cyc(0, 0, 1, 0);
        chk_model("lap_clear");
`endif

        // Random pulses checked every cycle.
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 4000; i++) begin
            bit t, s, c, l;
            t = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 39) == 0);
            c = ($urandom_range(0, 499) == 0);
            l = ($urandom_range(0, 49) == 0);
            cyc(t, s, c, l);
            chk_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
